board_shift_engine: RTL and testbench

//  Iterative diagonal shifter for packed checkers boards (dark squares only, square 0 top-left, row-major).

---
 rtl/board_shift_engine_if.sv | 36 +++
 rtl/board_shift_engine.sv | 196 +++++++++++++++++++
 tb/tb_board_shift_engine.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/board_shift_engine_if.sv
// Request/response bundle for board_shift_engine.
//  master: requester side (move generator / query logic)
//  slave : the shift engine
//  Request : in_valid, in_ready, in_board[N], in_dir[2], in_steps[SW], in_fill
//  Response: out_valid, out_ready, out_board[N], out_trail[N], out_sat
interface board_shift_engine_if #(
    parameter int unsigned ROWS      = 8,
    parameter int unsigned COLS      = 4,
    parameter int unsigned MAX_STEPS = 7
);
    localparam int unsigned N  = ROWS * COLS;
    localparam int unsigned SW = $clog2(MAX_STEPS + 1) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_board;
    logic [1:0]    in_dir;
    logic [SW-1:0] in_steps;
    logic          in_fill;

    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_board;
    logic [N-1:0]  out_trail;
    logic          out_sat;

    modport master (
        output in_valid, in_board, in_dir, in_steps, in_fill, out_ready,
        input  in_ready, out_valid, out_board, out_trail, out_sat
    );

    modport slave (
        input  in_valid, in_board, in_dir, in_steps, in_fill, out_ready,
        output in_ready, out_valid, out_board, out_trail, out_sat
    );
endinterface

// File: rtl/board_shift_engine.sv
// Iterative diagonal shifter for packed checkers boards (dark squares only,
// square 0 top-left, row-major). One single-square diagonal shift per clock;
// returns the final board and the OR of every intermediate board.
// Ports:
//  clock : rising-edge clock
//  reset : asynchronous, active-high
//  bus   : board_shift_engine_if.slave (request valid/ready + response valid/ready)
module board_shift_engine #(
    parameter int unsigned ROWS      = 8,
    parameter int unsigned COLS      = 4,
    parameter int unsigned MAX_STEPS = 7
) (
    input  logic                  clock,
    input  logic                  reset,
    board_shift_engine_if.slave   bus
);
    localparam int unsigned N  = ROWS * COLS;
    localparam int unsigned SW = $clog2(MAX_STEPS + 1) + 1;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int          RI = int'(ROWS);
    localparam int          CI = int'(COLS);

    localparam logic [SW-1:0] MAX_N = SW'(MAX_STEPS);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [1:0] DIR_UL = 2'd0;
    localparam logic [1:0] DIR_UR = 2'd1;
    localparam logic [1:0] DIR_DL = 2'd2;

    // One diagonal step: each square pulls from its neighbour in the opposite
    // direction, or takes the fill value when that neighbour is off-board.
    function automatic logic [N-1:0] shift_once(
        input logic [N-1:0] a,
        input logic [1:0]   dir_v,
        input logic         fill_v
    );
        logic [N-1:0] res;
        int           r;
        int           c;
        int           src;
        logic         ok;
        res = '0;
        for (int i = 0; i < int'(N); i++) begin
            r   = i / CI;
            c   = i % CI;
            src = 0;
            ok  = 1'b0;
            case (dir_v)
                DIR_UL: begin // source = DR neighbour
                    if (r % 2 == 0) begin
                        src = i + CI;
                        ok  = 1'b1;
                    end else begin
                        src = i + CI + 1;
                        ok  = (c < CI - 1) && (r < RI - 1);
                    end
                end
                DIR_UR: begin // source = DL neighbour
                    if (r % 2 == 0) begin
                        src = i + CI - 1;
                        ok  = (c > 0);
                    end else begin
                        src = i + CI;
                        ok  = (r < RI - 1);
                    end
                end
                DIR_DL: begin // source = UR neighbour
                    if (r % 2 == 0) begin
                        src = i - CI;
                        ok  = (r > 0);
                    end else begin
                        src = i - CI + 1;
                        ok  = (c < CI - 1);
                    end
                end
                default: begin // DR, source = UL neighbour
                    if (r % 2 == 0) begin
                        src = i - CI - 1;
                        ok  = (r > 0) && (c > 0);
                    end else begin
                        src = i - CI;
                        ok  = 1'b1;
                    end
                end
            endcase
            res[IW'(i)] = ok ? a[IW'(src)] : fill_v;
        end
        return res;
    endfunction

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [N-1:0]  cur;
    logic [N-1:0]  trail;
    logic [N-1:0]  shifted;
    logic [1:0]    dir;
    logic          fill;
    logic [SW-1:0] cnt;
    logic [SW-1:0] n_req;
    logic          sat;
    logic          out_valid_q;

    // Step request clamped to the largest honoured count.
    always_comb begin
        n_req   = (bus.in_steps > MAX_N) ? MAX_N : bus.in_steps;
        shifted = shift_once(cur, dir, fill);
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; in_ready is the only combinational output.
    always_comb begin
        state_next   = state;
        bus.in_ready = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_next = (n_req == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == SW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // out_valid is registered one edge behind DONE entry, so the
                // handshake must wait for it.
                if (out_valid_q && bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: latch request, iterate shifts, hold result until taken.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur         <= '0;
            trail       <= '0;
            dir         <= '0;
            fill        <= 1'b0;
            cnt         <= '0;
            sat         <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        cur   <= bus.in_board;
                        trail <= '0;
                        dir   <= bus.in_dir;
                        fill  <= bus.in_fill;
                        cnt   <= n_req;
                        sat   <= (bus.in_steps > MAX_N);
                    end
                end
                SHIFT: begin
                    cur   <= shifted;
                    trail <= trail | shifted;
                    cnt   <= cnt - SW'(1);
                end
                DONE: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_board = cur;
    assign bus.out_trail = trail;
    assign bus.out_sat   = sat;

endmodule

// File: tb/tb_board_shift_engine.sv
// Self-checking bench for board_shift_engine: directed vectors, randomized
// requests against a grid-coordinate reference model, stall, reset, back-to-back.
module tb_board_shift_engine;
    localparam int unsigned ROWS      = 8;
    localparam int unsigned COLS      = 4;
    localparam int unsigned MAX_STEPS = 7;
    localparam int unsigned N         = ROWS * COLS;
    localparam int unsigned SW        = $clog2(MAX_STEPS + 1) + 1;
    localparam int unsigned IW        = $clog2(N);

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    board_shift_engine_if #(.ROWS(ROWS), .COLS(COLS), .MAX_STEPS(MAX_STEPS)) bus ();

    board_shift_engine #(.ROWS(ROWS), .COLS(COLS), .MAX_STEPS(MAX_STEPS)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Reference: place each dark square on the full ROWS x 2*COLS grid and
    // pull from (y-dy, x-dx); off-grid sources yield the fill value.
    function automatic logic [N-1:0] model_step(input logic [N-1:0] b, input logic [1:0] d, input logic f);
        logic [N-1:0] res;
        int dy, dx, y, x, sy, sx;
        dy = d[1] ? 1 : -1;
        dx = d[0] ? 1 : -1;
        res = '0;
        for (int sq = 0; sq < int'(N); sq++) begin
            y  = sq / int'(COLS);
            x  = 2 * (sq % int'(COLS)) + (y % 2);
            sy = y - dy;
            sx = x - dx;
            if (sy >= 0 && sy < int'(ROWS) && sx >= 0 && sx < 2 * int'(COLS))
                res[IW'(sq)] = b[IW'(sy * int'(COLS) + sx / 2)];
            else
                res[IW'(sq)] = f;
        end
        return res;
    endfunction

    task automatic model_run(input logic [N-1:0] b, input logic [1:0] d, input int steps, input logic f,
                             output logic [N-1:0] ob, output logic [N-1:0] ot, output logic os, output int lat);
        int n;
        n  = (steps > int'(MAX_STEPS)) ? int'(MAX_STEPS) : steps;
        ob = b;
        ot = '0;
        for (int k = 0; k < n; k++) begin
            ob = model_step(ob, d, f);
            ot = ot | ob;
        end
        os  = (steps > int'(MAX_STEPS));
        lat = n + 1;
    endtask

    // Issue one request from IDLE; returns edges from accept to out_valid (capped).
    task automatic do_request(input logic [N-1:0] b, input logic [1:0] d, input int s, input logic f, output int edges);
        @(negedge clock);
        bus.in_board = b;
        bus.in_dir   = d;
        bus.in_steps = SW'(s);
        bus.in_fill  = f;
        bus.in_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        edges = 0;
        while (bus.out_valid !== 1'b1 && edges < 64) begin
            @(posedge clock);
            #1;
            edges++;
        end
    endtask

    task automatic release_result();
        @(negedge clock);
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_board !== '0) begin failures++; $display("FAIL reset_out_board got=%h exp=0", bus.out_board); end
        checks++; if (bus.out_trail !== '0) begin failures++; $display("FAIL reset_out_trail got=%h exp=0", bus.out_trail); end
        checks++; if (bus.out_sat !== 1'b0) begin failures++; $display("FAIL reset_out_sat got=%b exp=0", bus.out_sat); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_directed();
        logic [N-1:0] b_exp [3];
        logic [N-1:0] t_exp [3];
        logic [N-1:0] b_in  [3];
        logic [1:0]   d_in  [3];
        int           s_in  [3];
        logic         f_in  [3];
        int           e;
        b_in[0] = 32'h0000_0010; d_in[0] = 2'd0; s_in[0] = 1; f_in[0] = 1'b1; b_exp[0] = 32'hF080_8081; t_exp[0] = 32'hF080_8081;
        b_in[1] = 32'h0200_0000; d_in[1] = 2'd0; s_in[1] = 3; f_in[1] = 1'b0; b_exp[1] = 32'h0000_0000; t_exp[1] = 32'h0011_0000;
        b_in[2] = 32'h0000_0001; d_in[2] = 2'd3; s_in[2] = 2; f_in[2] = 1'b0; b_exp[2] = 32'h0000_0200; t_exp[2] = 32'h0000_0210;
        for (int v = 0; v < 3; v++) begin
            do_request(b_in[v], d_in[v], s_in[v], f_in[v], e);
            checks++; if (e !== s_in[v] + 1) begin failures++; $display("FAIL directed%0d_latency got=%0d exp=%0d", v, e, s_in[v] + 1); end
            checks++; if (bus.out_board !== b_exp[v]) begin failures++; $display("FAIL directed%0d_board got=%h exp=%h", v, bus.out_board, b_exp[v]); end
            checks++; if (bus.out_trail !== t_exp[v]) begin failures++; $display("FAIL directed%0d_trail got=%h exp=%h", v, bus.out_trail, t_exp[v]); end
            checks++; if (bus.out_sat !== 1'b0) begin failures++; $display("FAIL directed%0d_sat got=%b exp=0", v, bus.out_sat); end
            release_result();
        end
    endtask

    task automatic test_zero_steps();
        int e;
        do_request(32'hDEAD_BEEF, 2'd2, 0, 1'b1, e);
        checks++; if (e !== 1) begin failures++; $display("FAIL zero_latency got=%0d exp=1", e); end
        checks++; if (bus.out_board !== 32'hDEAD_BEEF) begin failures++; $display("FAIL zero_board got=%h exp=deadbeef", bus.out_board); end
        checks++; if (bus.out_trail !== '0) begin failures++; $display("FAIL zero_trail got=%h exp=0", bus.out_trail); end
        release_result();
    endtask

    task automatic test_saturation();
        logic [N-1:0] b, eb, et;
        logic         es;
        int           el, e;
        b = N'($urandom);
        model_run(b, 2'd1, 9, 1'b0, eb, et, es, el);
        do_request(b, 2'd1, 9, 1'b0, e);
        checks++; if (e !== 8) begin failures++; $display("FAIL sat_latency got=%0d exp=8", e); end
        checks++; if (bus.out_sat !== 1'b1) begin failures++; $display("FAIL sat_flag got=%b exp=1", bus.out_sat); end
        checks++; if (bus.out_board !== eb) begin failures++; $display("FAIL sat_board got=%h exp=%h", bus.out_board, eb); end
        checks++; if (bus.out_trail !== et) begin failures++; $display("FAIL sat_trail got=%h exp=%h", bus.out_trail, et); end
        release_result();
    endtask

    task automatic test_stall();
        logic [N-1:0] b, eb, et;
        logic         es;
        int           el, e, extra;
        b = N'($urandom);
        model_run(b, 2'd1, 4, 1'b1, eb, et, es, el);
        do_request(b, 2'd1, 4, 1'b1, e);
        checks++; if (e !== el) begin failures++; $display("FAIL stall_latency got=%0d exp=%0d", e, el); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            if (k == 2) begin
                bus.in_board = ~b;
                bus.in_steps = SW'(0);
                bus.in_valid = 1'b1;
            end
            @(posedge clock);
            #1;
            bus.in_valid = 1'b0;
            checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL stall%0d_valid got=%b exp=1", k, bus.out_valid); end
            checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL stall%0d_in_ready got=%b exp=0", k, bus.in_ready); end
            checks++; if (bus.out_board !== eb) begin failures++; $display("FAIL stall%0d_board got=%h exp=%h", k, bus.out_board, eb); end
            checks++; if (bus.out_trail !== et) begin failures++; $display("FAIL stall%0d_trail got=%h exp=%h", k, bus.out_trail, et); end
        end
        release_result();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL stall_release_valid got=%b exp=0", bus.out_valid); end
        extra = 0;
        repeat (4) begin
            @(posedge clock);
            #1;
            if (bus.out_valid === 1'b1) extra++;
        end
        checks++; if (extra !== 0) begin failures++; $display("FAIL stall_ignored_req got=%0d exp=0", extra); end
    endtask

    task automatic test_reset_midshift();
        logic [N-1:0] b, eb, et;
        logic         es;
        int           el, e, seen;
        @(negedge clock);
        bus.in_board = N'($urandom);
        bus.in_dir   = 2'd3;
        bus.in_steps = SW'(7);
        bus.in_fill  = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_board !== '0) begin failures++; $display("FAIL midrst_board got=%h exp=0", bus.out_board); end
        checks++; if (bus.out_trail !== '0) begin failures++; $display("FAIL midrst_trail got=%h exp=0", bus.out_trail); end
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        repeat (10) begin
            @(posedge clock);
            #1;
            if (bus.out_valid === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL midrst_discard got=%0d exp=0", seen); end
        b = N'($urandom);
        model_run(b, 2'd2, 5, 1'b0, eb, et, es, el);
        do_request(b, 2'd2, 5, 1'b0, e);
        checks++; if (e !== el) begin failures++; $display("FAIL midrst_next_latency got=%0d exp=%0d", e, el); end
        checks++; if (bus.out_board !== eb) begin failures++; $display("FAIL midrst_next_board got=%h exp=%h", bus.out_board, eb); end
        checks++; if (bus.out_trail !== et) begin failures++; $display("FAIL midrst_next_trail got=%h exp=%h", bus.out_trail, et); end
        release_result();
    endtask

    task automatic test_random();
        logic [N-1:0] b, eb, et;
        logic [1:0]   d;
        logic         f, es;
        int           s, el, e;
        for (int t = 0; t < 40; t++) begin
            b = N'($urandom);
            d = 2'($urandom_range(0, 3));
            f = 1'($urandom_range(0, 1));
            s = int'($urandom_range(0, 15));
            model_run(b, d, s, f, eb, et, es, el);
            do_request(b, d, s, f, e);
            checks++; if (e !== el) begin failures++; $display("FAIL rand%0d_latency got=%0d exp=%0d", t, e, el); end
            checks++; if (bus.out_board !== eb) begin failures++; $display("FAIL rand%0d_board got=%h exp=%h (dir=%0d steps=%0d fill=%b)", t, bus.out_board, eb, d, s, f); end
            checks++; if (bus.out_trail !== et) begin failures++; $display("FAIL rand%0d_trail got=%h exp=%h", t, bus.out_trail, et); end
            checks++; if (bus.out_sat !== es) begin failures++; $display("FAIL rand%0d_sat got=%b exp=%b", t, bus.out_sat, es); end
            release_result();
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] b, eb, et;
        logic [1:0]   d;
        logic         f, es;
        int           s, el, e, g;
        bus.out_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            b = N'($urandom);
            d = 2'($urandom_range(0, 3));
            f = 1'($urandom_range(0, 1));
            s = int'($urandom_range(0, 9));
            model_run(b, d, s, f, eb, et, es, el);
            @(negedge clock);
            bus.in_board = b;
            bus.in_dir   = d;
            bus.in_steps = SW'(s);
            bus.in_fill  = f;
            bus.in_valid = 1'b1;
            g = 0;
            while (bus.in_ready !== 1'b1 && g < 50) begin
                @(negedge clock);
                g++;
            end
            checks++; if (g >= 50) begin failures++; $display("FAIL b2b%0d_ready_timeout got=%0d exp<50", t, g); end
            @(posedge clock);
            #1;
            bus.in_valid = 1'b0;
            e = 0;
            while (bus.out_valid !== 1'b1 && e < 64) begin
                @(posedge clock);
                #1;
                e++;
            end
            checks++; if (e !== el) begin failures++; $display("FAIL b2b%0d_latency got=%0d exp=%0d", t, e, el); end
            checks++; if (bus.out_board !== eb) begin failures++; $display("FAIL b2b%0d_board got=%h exp=%h", t, bus.out_board, eb); end
            checks++; if (bus.out_trail !== et) begin failures++; $display("FAIL b2b%0d_trail got=%h exp=%h", t, bus.out_trail, et); end
            checks++; if (bus.out_sat !== es) begin failures++; $display("FAIL b2b%0d_sat got=%b exp=%b", t, bus.out_sat, es); end
        end
        @(posedge clock);
        #1;
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_final_valid got=%b exp=0", bus.out_valid); end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_board  = '0;
        bus.in_dir    = 2'd0;
        bus.in_steps  = '0;
        bus.in_fill   = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_zero_steps();
        test_saturation();
        test_stall();
        test_reset_midshift();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
